// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
// Latency: n/a (definitions only). Backpressure: n/a.
// MC_EXT_INSTR_EN adds the JAL state and the jal/slti/lui opcodes.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH,
        ST_DECODE,
        ST_MEM_ADDR,
        ST_MEM_RD,
        ST_MEM_WR,
        ST_MEM_WB,
        ST_EXEC_R,
        ST_EXEC_SH,
        ST_EXEC_I,
        ST_ALU_WB,
        ST_ALU_WB_I,
        ST_BRANCH,
        ST_JUMP,
`ifdef MC_EXT_INSTR_EN
        ST_JR,
        ST_JAL
`else
        ST_JR
`endif
    } state_t;

    // Operation class chosen by the FSM; AOP_FUNCT defers to the R-type funct field.
    typedef enum logic [2:0] {
        AOP_ADD,
        AOP_SUB,
        AOP_AND,
        AOP_OR,
        AOP_SLT,
        AOP_LUI,
        AOP_FUNCT
    } alu_op_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SLL = 4'd3;
    localparam logic [3:0] ALU_SRL = 4'd4;
    localparam logic [3:0] ALU_SRA = 4'd5;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_LUI = 4'd8;

    localparam logic [1:0] REG_DST_RT = 2'd0;
    localparam logic [1:0] REG_DST_RD = 2'd1;
    localparam logic [1:0] REG_DST_RA = 2'd2;

    localparam logic [1:0] MEM_TO_REG_ALUOUT = 2'd0;
    localparam logic [1:0] MEM_TO_REG_MDR    = 2'd1;
    localparam logic [1:0] MEM_TO_REG_PC     = 2'd2;

    localparam logic [1:0] ALU_A_PC    = 2'd0;
    localparam logic [1:0] ALU_A_REG   = 2'd1;
    localparam logic [1:0] ALU_A_SHAMT = 2'd2;

    localparam logic [2:0] ALU_B_REG     = 3'd0;
    localparam logic [2:0] ALU_B_FOUR    = 3'd1;
    localparam logic [2:0] ALU_B_SEXT    = 3'd2;
    localparam logic [2:0] ALU_B_SEXT_SH = 3'd3;
    localparam logic [2:0] ALU_B_ZEXT    = 3'd4;

    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
    localparam logic [1:0] PC_SRC_REG    = 2'd3;

endpackage

// File: rtl/mc_alu_dec.sv
// ALU control decoder: FSM op class plus funct to ALU operation code.
// Latency: combinational. Backpressure: none.
// funct_illegal depends on funct alone so DECODE can use it for any class.
module mc_alu_dec
    import mc_ctrl_pkg::*;
#(
    parameter int ALU_W = 4
) (
    input  alu_op_t          alu_op,
    input  logic [5:0]       funct,
    output logic [ALU_W-1:0] alu_ctrl,
    output logic             funct_illegal
);

    logic [3:0] funct_code;
    logic [3:0] code;

    always_comb begin
        funct_code    = ALU_ADD;
        funct_illegal = 1'b0;
        case (funct)
            FN_ADD:  funct_code = ALU_ADD;
            FN_SUB:  funct_code = ALU_SUB;
            FN_AND:  funct_code = ALU_AND;
            FN_OR:   funct_code = ALU_OR;
            FN_SLT:  funct_code = ALU_SLT;
            FN_SLL,
            FN_SLLV: funct_code = ALU_SLL;
            FN_SRL,
            FN_SRLV: funct_code = ALU_SRL;
            FN_SRA,
            FN_SRAV: funct_code = ALU_SRA;
            FN_JR:   funct_code = ALU_ADD;
            default: funct_illegal = 1'b1;
        endcase
    end

    always_comb begin
        code = ALU_ADD;
        case (alu_op)
            AOP_ADD:   code = ALU_ADD;
            AOP_SUB:   code = ALU_SUB;
            AOP_AND:   code = ALU_AND;
            AOP_OR:    code = ALU_OR;
            AOP_SLT:   code = ALU_SLT;
            AOP_LUI:   code = ALU_LUI;
            AOP_FUNCT: code = funct_code;
            default:   code = ALU_ADD;
        endcase
    end

    assign alu_ctrl = ALU_W'(code);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM with req/ready memory handshake and bounded wait.
// Latency: lw 5, sw/R/I 4, branch/jump 3 cycles, plus one per memory wait cycle.
// Backpressure: stalls while mem_ready is low; MAX_WAIT waits abort to FETCH. MC_EXT_INSTR_EN adds jal/slti/lui.
module multicycle_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int ALU_W    = 4,
    parameter int MAX_WAIT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_we,
    output logic             pc_we,
    output logic             reg_we,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic [1:0]       alu_src_a,
    output logic [2:0]       alu_src_b,
    output logic [1:0]       pc_src,
    output logic [ALU_W-1:0] alu_ctrl,
    output logic             illegal,
    output logic             mem_timeout
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

    state_t           state;
    state_t           decode_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic             req_state;
    logic             waiting;
    logic             timeout;
    logic             decode_illegal;
    logic             funct_illegal;
    alu_op_t          alu_op;

    logic mem_req_raw, mem_we_raw, ir_we_raw, pc_we_raw, reg_we_raw, illegal_raw;

    mc_alu_dec #(
        .ALU_W(ALU_W)
    ) u_alu_dec (
        .alu_op       (alu_op),
        .funct        (funct),
        .alu_ctrl     (alu_ctrl),
        .funct_illegal(funct_illegal)
    );

    // The wait counter only runs in request states; any other state holds it at zero.
    always_comb begin
        req_state = (state == ST_FETCH) || (state == ST_MEM_RD) || (state == ST_MEM_WR);
        waiting   = req_state && !mem_ready;
        timeout   = waiting && (wait_cnt == WAIT_LAST);
    end

    always_comb begin
        decode_nxt     = ST_FETCH;
        decode_illegal = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                if (funct_illegal)
                    decode_illegal = 1'b1;
                else if (funct == FN_JR)
                    decode_nxt = ST_JR;
                else if ((funct == FN_SLL) || (funct == FN_SRL) || (funct == FN_SRA))
                    decode_nxt = ST_EXEC_SH;
                else
                    decode_nxt = ST_EXEC_R;
            end
            OP_LW, OP_SW:             decode_nxt = ST_MEM_ADDR;
            OP_BEQ, OP_BNE:           decode_nxt = ST_BRANCH;
            OP_J:                     decode_nxt = ST_JUMP;
            OP_ADDI, OP_ANDI, OP_ORI: decode_nxt = ST_EXEC_I;
`ifdef MC_EXT_INSTR_EN
            OP_SLTI, OP_LUI:          decode_nxt = ST_EXEC_I;
            OP_JAL:                   decode_nxt = ST_JAL;
`endif
            default:                  decode_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_FETCH;
            wait_cnt <= '0;
        end else begin
            wait_cnt <= (waiting && !timeout) ? wait_cnt + CNT_W'(1) : '0;
            case (state)
                ST_FETCH:    if (mem_ready) state <= ST_DECODE;
                ST_DECODE:   state <= decode_nxt;
                ST_MEM_ADDR: state <= (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
                ST_MEM_RD: begin
                    if (mem_ready)
                        state <= ST_MEM_WB;
                    else if (timeout)
                        state <= ST_FETCH;
                end
                ST_MEM_WR:   if (mem_ready || timeout) state <= ST_FETCH;
                ST_EXEC_R,
                ST_EXEC_SH:  state <= ST_ALU_WB;
                ST_EXEC_I:   state <= ST_ALU_WB_I;
                default:     state <= ST_FETCH;
            endcase
        end
    end

    always_comb begin
        mem_req_raw = 1'b0;
        mem_we_raw  = 1'b0;
        ir_we_raw   = 1'b0;
        pc_we_raw   = 1'b0;
        reg_we_raw  = 1'b0;
        illegal_raw = 1'b0;
        iord        = 1'b0;
        reg_dst     = REG_DST_RT;
        mem_to_reg  = MEM_TO_REG_ALUOUT;
        alu_src_a   = ALU_A_PC;
        alu_src_b   = ALU_B_REG;
        pc_src      = PC_SRC_ALU;
        alu_op      = AOP_ADD;
        case (state)
            ST_FETCH: begin
                mem_req_raw = 1'b1;
                alu_src_b   = ALU_B_FOUR;
                ir_we_raw   = mem_ready;
                pc_we_raw   = mem_ready;
            end
            ST_DECODE: begin
                alu_src_b   = ALU_B_SEXT_SH;
                illegal_raw = decode_illegal;
            end
            ST_MEM_ADDR: begin
                alu_src_a = ALU_A_REG;
                alu_src_b = ALU_B_SEXT;
            end
            ST_MEM_RD: begin
                mem_req_raw = 1'b1;
                iord        = 1'b1;
            end
            ST_MEM_WR: begin
                mem_req_raw = 1'b1;
                mem_we_raw  = 1'b1;
                iord        = 1'b1;
            end
            ST_MEM_WB: begin
                reg_we_raw = 1'b1;
                mem_to_reg = MEM_TO_REG_MDR;
            end
            ST_EXEC_R: begin
                alu_src_a = ALU_A_REG;
                alu_op    = AOP_FUNCT;
            end
            ST_EXEC_SH: begin
                alu_src_a = ALU_A_SHAMT;
                alu_op    = AOP_FUNCT;
            end
            ST_EXEC_I: begin
                alu_src_a = ALU_A_REG;
                alu_src_b = ALU_B_SEXT;
                case (opcode)
                    OP_ANDI: begin
                        alu_src_b = ALU_B_ZEXT;
                        alu_op    = AOP_AND;
                    end
                    OP_ORI: begin
                        alu_src_b = ALU_B_ZEXT;
                        alu_op    = AOP_OR;
                    end
`ifdef MC_EXT_INSTR_EN
                    OP_SLTI: alu_op = AOP_SLT;
                    OP_LUI: begin
                        alu_src_b = ALU_B_ZEXT;
                        alu_op    = AOP_LUI;
                    end
`endif
                    default: alu_op = AOP_ADD;
                endcase
            end
            ST_ALU_WB: begin
                reg_we_raw = 1'b1;
                reg_dst    = REG_DST_RD;
            end
            ST_ALU_WB_I: reg_we_raw = 1'b1;
            ST_BRANCH: begin
                alu_src_a = ALU_A_REG;
                alu_op    = AOP_SUB;
                pc_src    = PC_SRC_ALUOUT;
                pc_we_raw = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero);
            end
            ST_JUMP: begin
                pc_src    = PC_SRC_JUMP;
                pc_we_raw = 1'b1;
            end
            ST_JR: begin
                pc_src    = PC_SRC_REG;
                pc_we_raw = 1'b1;
            end
`ifdef MC_EXT_INSTR_EN
            // PC was already advanced in FETCH, so the link value is the current PC.
            ST_JAL: begin
                reg_we_raw = 1'b1;
                reg_dst    = REG_DST_RA;
                mem_to_reg = MEM_TO_REG_PC;
                pc_src     = PC_SRC_JUMP;
                pc_we_raw  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // State is already FETCH under reset; only strobes need explicit masking.
    assign mem_req     = mem_req_raw && !rst;
    assign mem_we      = mem_we_raw && !rst;
    assign ir_we       = ir_we_raw && !rst;
    assign pc_we       = pc_we_raw && !rst;
    assign reg_we      = reg_we_raw && !rst;
    assign illegal     = illegal_raw && !rst;
    assign mem_timeout = timeout && !rst;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: instruction vector table plus handshake/reset corner sequences.
module tb_multicycle_ctrl;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, mem_we, iord, ir_we, pc_we, reg_we, illegal, mem_timeout;
    logic [1:0] reg_dst, mem_to_reg, alu_src_a, pc_src;
    logic [2:0] alu_src_b;
    logic [3:0] alu_ctrl;

    int total = 0;
    int bad   = 0;

    multicycle_ctrl #(.ALU_W(4), .MAX_WAIT(15)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .iord       (iord),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .reg_we     (reg_we),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .pc_src     (pc_src),
        .alu_ctrl   (alu_ctrl),
        .illegal    (illegal),
        .mem_timeout(mem_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-instruction expectations with mem_ready held high: cycle count, strobe
    // counts over the instruction, write-back selects, and datapath selects in cycle 3.
    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        int cycles;
        int n_reg;
        int n_pc;
        int n_ill;
        int n_mw;
        int dst;
        int m2r;
        int a3;
        int b3;
        int p3;
        int al3;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs [NV];

    task automatic chk(input string nm, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
        end
    endtask

    // Entered during a FETCH cycle; returns during the following FETCH cycle.
    task automatic run_instr(input int i);
        vec_t v;
        int cyc, nreg, npc, nill, nmw, nir, dst, m2r, a3, b3, p3, al3;
        v = vecs[i];
        opcode = v.op;
        funct = v.fn;
        zero = v.z;
        mem_ready = 1'b1;
        cyc = -1;
        nreg = 0; npc = 0; nill = 0; nmw = 0; nir = 0;
        dst = 0; m2r = 0; a3 = 0; b3 = 0; p3 = 0; al3 = 0;
        for (int c = 1; c <= 12; c++) begin
            if (c > 1) @(negedge clk);
            #1;
            if (c > 1 && mem_req && !iord) begin
                cyc = c - 1;
                break;
            end
            nreg += int'(reg_we);
            npc  += int'(pc_we);
            nill += int'(illegal);
            nmw  += int'(mem_we);
            nir  += int'(ir_we);
            if (reg_we) begin
                dst = int'(reg_dst);
                m2r = int'(mem_to_reg);
            end
            if (c == 3) begin
                a3  = int'(alu_src_a);
                b3  = int'(alu_src_b);
                p3  = int'(pc_src);
                al3 = int'(alu_ctrl);
            end
        end
        chk($sformatf("v%0d.cycles", i), cyc, v.cycles);
        chk($sformatf("v%0d.ir_we_count", i), nir, 1);
        chk($sformatf("v%0d.reg_we_count", i), nreg, v.n_reg);
        chk($sformatf("v%0d.pc_we_count", i), npc, v.n_pc);
        chk($sformatf("v%0d.illegal_count", i), nill, v.n_ill);
        chk($sformatf("v%0d.mem_we_count", i), nmw, v.n_mw);
        if (v.n_reg > 0) begin
            chk($sformatf("v%0d.reg_dst", i), dst, v.dst);
            chk($sformatf("v%0d.mem_to_reg", i), m2r, v.m2r);
        end
        if (v.cycles >= 3) begin
            chk($sformatf("v%0d.alu_src_a_c3", i), a3, v.a3);
            chk($sformatf("v%0d.alu_src_b_c3", i), b3, v.b3);
            chk($sformatf("v%0d.pc_src_c3", i), p3, v.p3);
            chk($sformatf("v%0d.alu_ctrl_c3", i), al3, v.al3);
        end
    endtask

    initial begin
        int n, to_n, to_at, ir_n;
        //             op     fn     z     cyc reg pc ill mw dst m2r a3 b3 p3 alu
        vecs[0]  = '{6'h23, 6'h00, 1'b0, 5, 1, 1, 0, 0, 0, 1, 1, 2, 0, 2};  // lw
        vecs[1]  = '{6'h2B, 6'h00, 1'b0, 4, 0, 1, 0, 1, 0, 0, 1, 2, 0, 2};  // sw
        vecs[2]  = '{6'h00, 6'h20, 1'b0, 4, 1, 1, 0, 0, 1, 0, 1, 0, 0, 2};  // add
        vecs[3]  = '{6'h00, 6'h22, 1'b0, 4, 1, 1, 0, 0, 1, 0, 1, 0, 0, 6};  // sub
        vecs[4]  = '{6'h00, 6'h24, 1'b0, 4, 1, 1, 0, 0, 1, 0, 1, 0, 0, 0};  // and
        vecs[5]  = '{6'h00, 6'h25, 1'b0, 4, 1, 1, 0, 0, 1, 0, 1, 0, 0, 1};  // or
        vecs[6]  = '{6'h00, 6'h2A, 1'b0, 4, 1, 1, 0, 0, 1, 0, 1, 0, 0, 7};  // slt
        vecs[7]  = '{6'h00, 6'h04, 1'b0, 4, 1, 1, 0, 0, 1, 0, 1, 0, 0, 3};  // sllv
        vecs[8]  = '{6'h00, 6'h07, 1'b0, 4, 1, 1, 0, 0, 1, 0, 1, 0, 0, 5};  // srav
        vecs[9]  = '{6'h00, 6'h02, 1'b0, 4, 1, 1, 0, 0, 1, 0, 2, 0, 0, 4};  // srl
        vecs[10] = '{6'h00, 6'h03, 1'b0, 4, 1, 1, 0, 0, 1, 0, 2, 0, 0, 5};  // sra
        vecs[11] = '{6'h08, 6'h00, 1'b0, 4, 1, 1, 0, 0, 0, 0, 1, 2, 0, 2};  // addi
        vecs[12] = '{6'h0C, 6'h00, 1'b0, 4, 1, 1, 0, 0, 0, 0, 1, 4, 0, 0};  // andi
        vecs[13] = '{6'h0D, 6'h00, 1'b0, 4, 1, 1, 0, 0, 0, 0, 1, 4, 0, 1};  // ori
        vecs[14] = '{6'h04, 6'h00, 1'b1, 3, 0, 2, 0, 0, 0, 0, 1, 0, 1, 6};  // beq taken
        vecs[15] = '{6'h04, 6'h00, 1'b0, 3, 0, 1, 0, 0, 0, 0, 1, 0, 1, 6};  // beq not taken
        vecs[16] = '{6'h05, 6'h00, 1'b1, 3, 0, 1, 0, 0, 0, 0, 1, 0, 1, 6};  // bne not taken
        vecs[17] = '{6'h05, 6'h00, 1'b0, 3, 0, 2, 0, 0, 0, 0, 1, 0, 1, 6};  // bne taken
        vecs[18] = '{6'h02, 6'h00, 1'b0, 3, 0, 2, 0, 0, 0, 0, 0, 0, 2, 2};  // j
        vecs[19] = '{6'h00, 6'h08, 1'b0, 3, 0, 2, 0, 0, 0, 0, 0, 0, 3, 2};  // jr
        vecs[20] = '{6'h3F, 6'h00, 1'b0, 2, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0};  // bad opcode
        vecs[21] = '{6'h00, 6'h01, 1'b0, 2, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0};  // bad funct
`ifdef MC_EXT_INSTR_EN
        vecs[22] = '{6'h03, 6'h00, 1'b0, 3, 1, 2, 0, 0, 2, 2, 0, 0, 2, 2};  // jal
        vecs[23] = '{6'h0F, 6'h00, 1'b0, 4, 1, 1, 0, 0, 0, 0, 1, 4, 0, 8};  // lui
        vecs[24] = '{6'h0A, 6'h00, 1'b0, 4, 1, 1, 0, 0, 0, 0, 1, 2, 0, 7};  // slti
`else
        vecs[22] = '{6'h03, 6'h00, 1'b0, 2, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0};  // jal
        vecs[23] = '{6'h0F, 6'h00, 1'b0, 2, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0};  // lui
        vecs[24] = '{6'h0A, 6'h00, 1'b0, 2, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0};  // slti
`endif

        rst = 1'b1;
        mem_ready = 1'b1;
        opcode = 6'h00;
        funct = 6'h20;
        zero = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_mem_req", int'(mem_req), 0);
        chk("rst_ir_we", int'(ir_we), 0);
        chk("rst_pc_we", int'(pc_we), 0);
        chk("rst_mem_timeout", int'(mem_timeout), 0);
        chk("rst_alu_src_b", int'(alu_src_b), 1);
        chk("rst_alu_ctrl", int'(alu_ctrl), 2);
        chk("rst_iord", int'(iord), 0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) run_instr(i);

        // sw with three MEM_WR wait cycles
        opcode = 6'h2B;
        mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        mem_ready = 1'b0;
        n = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            n += int'(mem_req && mem_we && iord);
        end
        @(posedge clk);
        #1;
        mem_ready = 1'b1;
        @(negedge clk);
        #1;
        n += int'(mem_req && mem_we && iord);
        chk("sw_wait_req_cycles", n, 4);
        @(negedge clk);
        #1;
        chk("sw_wait_then_fetch_req", int'(mem_req), 1);
        chk("sw_wait_then_fetch_iord", int'(iord), 0);
        chk("sw_wait_then_fetch_we", int'(mem_we), 0);

        // FETCH timeout after 15 wait cycles, then retry
        mem_ready = 1'b0;
        to_n = 0;
        to_at = -1;
        ir_n = 0;
        for (int c = 1; c <= 15; c++) begin
            if (c > 1) @(negedge clk);
            #1;
            if (mem_timeout) begin
                to_n++;
                to_at = c;
            end
            ir_n += int'(ir_we);
        end
        chk("fetch_timeout_count", to_n, 1);
        chk("fetch_timeout_cycle", to_at, 15);
        chk("fetch_timeout_no_ir_we", ir_n, 0);
        @(negedge clk);
        #1;
        chk("fetch_retry_req", int'(mem_req), 1);
        chk("fetch_retry_iord", int'(iord), 0);
        chk("fetch_retry_timeout_clear", int'(mem_timeout), 0);
        mem_ready = 1'b1;
        #1;
        chk("fetch_retry_ir_we", int'(ir_we), 1);

        // reset in the middle of a stalled MEM_RD
        opcode = 6'h23;
        @(negedge clk);
        @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("memrd_req", int'(mem_req), 1);
        chk("memrd_iord", int'(iord), 1);
        rst = 1'b1;
        #1;
        chk("rst_mid_req", int'(mem_req), 0);
        chk("rst_mid_iord", int'(iord), 0);
        chk("rst_mid_reg_we", int'(reg_we), 0);
        chk("rst_mid_pc_we", int'(pc_we), 0);
        @(negedge clk);
        #1;
        chk("rst_hold_req", int'(mem_req), 0);
        rst = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk("rst_release_fetch_req", int'(mem_req), 1);
        chk("rst_release_fetch_iord", int'(iord), 0);
        chk("rst_release_ir_we", int'(ir_we), 1);
        run_instr(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Parametrised multicycle MIPS control unit: the next generation of the fixed 19-bit-word controller, generalised for variable-latency memory, a wider ALU control field and an optional extended instruction set. It sits between the instruction register (`opcode`/`funct`), the ALU `zero` flag and the datapath mux/enable inputs. It drives a req/ready handshake to unified memory with a bounded wait counter and flags illegal instructions instead of producing X states.

## Interface
Parameters:
- `ALU_W`, 4: ALU control width, ≥4. Codes are zero-extended.
- `MAX_WAIT`, 15: maximum cycles `mem_req` may wait for `mem_ready` before timeout, ≥1.

Ports:
- Reset `rst`, asynchronous, active-high; clock `clk`.
- `opcode`  in  6  IR[31:26]
- `funct`  in  6  IR[5:0]
- `zero`  in  1  ALU zero flag
- `mem_ready`  in  1  memory completes current access this cycle
- `mem_req`  out  1  memory access request
- `mem_we`  out  1  memory write (valid with `mem_req`)
- `iord`  out  1  0 = PC address, 1 = ALUOut address
- `ir_we`  out  1  load IR
- `pc_we`  out  1  load PC
- `reg_we`  out  1  register file write
- `reg_dst`  out  2  0 = rt, 1 = rd, 2 = r31
- `mem_to_reg`  out  2  0 = ALUOut, 1 = MDR, 2 = PC
- `alu_src_a`  out  2  0 = PC, 1 = A, 2 = shamt
- `alu_src_b`  out  3  0 = B, 1 = 4, 2 = sext imm, 3 = sext imm<<2, 4 = zext imm
- `pc_src`  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target, 3 = A
- `alu_ctrl`  out  ALU_W  ALU operation
- `illegal`  out  1  one-cycle pulse on an undefined opcode/funct
- `mem_timeout`  out  1  one-cycle pulse on a handshake timeout

## Operation
- ALU codes: and 0, or 1, add 2, sll 3, srl 4, sra 5, sub 6, slt 7, lui 8.
- States and transitions:
  - FETCH → DECODE.
  - DECODE → MEM_ADDR (lw/sw), BRANCH (beq/bne), JUMP (j), JR, EXEC_SH (sll/srl/sra), EXEC_R (other legal R-type funct), EXEC_I (addi/andi/ori and, with the extension, slti/lui), JAL (extension only).
  - MEM_ADDR → MEM_RD (lw) or MEM_WR (sw). MEM_RD → MEM_WB.
  - EXEC_R and EXEC_SH → ALU_WB. EXEC_I → ALU_WB_I.
  - All other states → FETCH.
- Legal R-type funct: add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A, sllv 0x04, srlv 0x06, srav 0x07, sll 0x00, srl 0x02, sra 0x03, jr 0x08.
- FETCH: `mem_req`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=1, `pc_src`=0, add. In the cycle `mem_ready`=1: `ir_we`=1 and `pc_we`=1.
- DECODE: `alu_src_b`=3, add (branch target into ALUOut).
- MEM_RD and MEM_WR: `mem_req`=1, `iord`=1. `mem_we`=1 in MEM_WR. The state advances only in the cycle `mem_ready`=1.
- BRANCH: `alu_src_a`=1, `alu_src_b`=0, sub, `pc_src`=1. `pc_we` = (beq & zero) | (bne & ~zero), combinational.
- JUMP: `pc_src`=2, `pc_we`=1. JR: `pc_src`=3, `pc_we`=1.
- JAL: `reg_we`=1, `reg_dst`=2, `mem_to_reg`=2 (PC already +4), `pc_src`=2, `pc_we`=1.
- ALU_WB: `reg_we`, `reg_dst`=1. ALU_WB_I: `reg_we`, `reg_dst`=0. MEM_WB: `reg_we`, `mem_to_reg`=1.
- andi, ori and lui use `alu_src_b`=4; addi and slti use 2.
- Illegal opcode/funct in DECODE: `illegal`=1 for one cycle, next state FETCH, no enables asserted.

## Timing
- Zero-wait latency: lw 5, sw/R/I 4, beq/bne/j/jr/jal 3 cycles.
- Each cycle with `mem_req`=1 and `mem_ready`=0 adds one cycle.
- Wait counter: clears on state entry, increments while waiting. Reaching `MAX_WAIT` without ready → `mem_timeout` pulse and → FETCH with no IR/PC/register write. Timeout in FETCH retries the same PC.
- `mem_ready` outside a request is ignored.
- Reset (async, any state, mid-access included): state FETCH, counter 0. While `rst`=1: `mem_req`, `mem_we`, `ir_we`, `pc_we`, `reg_we`, `illegal`, `mem_timeout` = 0. Selects take FETCH values.
- All outputs are combinational from state, plus `mem_ready`/`zero`/`opcode`/`funct` where stated. No output is ever X.

## Configuration
- `MC_EXT_INSTR_EN` defined: jal (0x03), slti (0x0A → slt), lui (0x0F → lui) decode and execute as above.
- Undefined: these three opcodes take the illegal path, and the JAL state is not compiled.

## Structure
- Package `mc_ctrl_pkg` holds:
  - the state enum;
  - opcode and funct constants;
  - ALU code constants;
  - mux-select encodings for `reg_dst`, `mem_to_reg`, `alu_src_a`, `alu_src_b`, `pc_src`.
- Sub-module `mc_alu_dec` is combinational: state-derived op class + funct → `alu_ctrl`, with an illegal-funct flag.

## Test plan
- lw with `mem_ready` held high → 5 cycles, `reg_we`=1 with `mem_to_reg`=1 in cycle 5, one `ir_we` pulse.
- sw with `mem_ready` low 3 cycles in MEM_WR → `mem_req`/`mem_we` held for 4 cycles, FETCH follows.
- beq with zero=1 → `pc_we`=1, `pc_src`=1. bne with zero=1 → `pc_we`=0. Both 3 cycles.
- `mem_ready` low for `MAX_WAIT`=15 cycles in FETCH → `mem_timeout` pulse, no `ir_we`, FETCH re-requests.
- opcode 0x3F → `illegal` pulse in DECODE, then FETCH. With the macro undefined, jal (0x03) → `illegal`.
- `rst` asserted mid-MEM_RD → all enables 0 immediately, FETCH after release.
